// File: rtl/debug_pkg.sv
// debug_pkg
// Shared types between the CP3 debug coprocessor and the pipeline-side halt
// sequencer (debug_halt_ctrl).
//   halt_cause_t : architectural halt cause encoding reported to the debugger
//   halt_state_t : sequencer state, also exported on the debug state port
//   entry_cause  : cause latched when the core leaves RUN on a halt request
package debug_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_BREAKPOINT = 3'd1,
    CAUSE_WATCHPOINT = 3'd2,
    CAUSE_EXTERNAL   = 3'd3,
    CAUSE_STEP       = 3'd4
  } halt_cause_t;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_HALTED     = 3'd2,
    ST_STEP_ISSUE = 3'd3,
    ST_STEP_WAIT  = 3'd4
  } halt_state_t;

  // Breakpoint outranks watchpoint; a bare request is an external halt.
  function automatic halt_cause_t entry_cause(input logic bp_hit, input logic wp_hit);
    if (bp_hit) begin
      return CAUSE_BREAKPOINT;
    end else if (wp_hit) begin
      return CAUSE_WATCHPOINT;
    end
    return CAUSE_EXTERNAL;
  endfunction

endpackage

// File: rtl/dbg_drain_timer.sv
// dbg_drain_timer
// Bounded cycle timer shared by the DRAIN and STEP_WAIT phases of the halt
// sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count back to zero (wins over en)
//   en         : advance the count by one this cycle
//   expired    : count has reached LIMIT-1 (the last allowed cycle)
module dbg_drain_timer #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // The count parks at LAST; the owner leaves the phase on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_halt_ctrl.sv
// debug_halt_ctrl
// Pipeline-side halt sequencer. Turns CP3 halt / single-step / breakpoint /
// watchpoint indications into fetch stall, drain and one-instruction step
// controls, captures the resume PC and halt cause, and reports "halted".
//
// Handshake with the debug path: debug_halt_request is a level. The core is
// stopped exactly while halted=1. Dropping the request while halted releases
// the core; resume_ack pulses for one cycle in the first RUN cycle. A
// debug_single_step pulse while halted runs one instruction and the block
// re-halts by itself with cause STEP, whatever the request level is.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   debug_halt_request      level from CP3, 1 = core must halt
//   debug_single_step       pulse from CP3, step one instruction (HALTED only)
//   debug_breakpoint_hit    cause qualifier sampled on the RUN->DRAIN edge
//   debug_watchpoint_hit    cause qualifier sampled on the RUN->DRAIN edge
//   pipe_empty              nothing in flight past fetch
//   retire_valid            one instruction retired this cycle
//   core_next_pc            PC fetch will use next
//   fetch_stall             block new fetches
//   step_issue              one-cycle pulse: fetch exactly one instruction
//   halted                  core drained and stopped
//   resume_ack              one-cycle pulse on leaving HALTED
//   halt_cause              halt_cause_t encoding
//   halt_pc                 resume PC captured on entry to HALTED
//   drain_timeout           the last drain was forced by the timer
//   halt_count              saturating count of entries to HALTED
//   dbg_state               current sequencer state
module debug_halt_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  debug_halt_request,
  input  logic                  debug_single_step,
  input  logic                  debug_breakpoint_hit,
  input  logic                  debug_watchpoint_hit,
  input  logic                  pipe_empty,
  input  logic                  retire_valid,
  input  logic [ADDR_WIDTH-1:0] core_next_pc,
  output logic                  fetch_stall,
  output logic                  step_issue,
  output logic                  halted,
  output logic                  resume_ack,
  output logic [2:0]            halt_cause,
  output logic [ADDR_WIDTH-1:0] halt_pc,
  output logic                  drain_timeout,
  output logic [CNT_WIDTH-1:0]  halt_count,
  output halt_state_t           dbg_state
);

  halt_state_t           state_q, state_d;
  halt_cause_t           cause_q, cause_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  fetch_stall_q, fetch_stall_d;
  logic                  step_issue_q, step_issue_d;
  logic                  halted_q, halted_d;
  logic                  resume_ack_q, resume_ack_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  // The timer restarts from zero on every state entry and only advances in
  // the two phases that wait on the pipeline.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == ST_DRAIN) || (state_q == ST_STEP_WAIT);

  dbg_drain_timer #(
    .LIMIT (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    timeout_d    = timeout_q;
    count_d      = count_q;
    resume_ack_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (debug_halt_request) begin
          state_d = ST_DRAIN;
          cause_d = entry_cause(debug_breakpoint_hit, debug_watchpoint_hit);
        end
      end
      ST_DRAIN: begin
        // pipe_empty is checked first so a tie with expiry is a clean drain.
        if (pipe_empty) begin
          state_d = ST_HALTED;
        end else if (tmr_expired) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end
      end
      ST_HALTED: begin
        // A step outranks a simultaneous request drop. Each step starts a
        // fresh halt attempt, so the timeout flag restarts with it.
        if (debug_single_step) begin
          state_d   = ST_STEP_ISSUE;
          timeout_d = 1'b0;
        end else if (!debug_halt_request) begin
          state_d      = ST_RUN;
          resume_ack_d = 1'b1;
          cause_d      = CAUSE_NONE;
          timeout_d    = 1'b0;
        end
      end
      ST_STEP_ISSUE: begin
        state_d = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        if (retire_valid) begin
          state_d = ST_DRAIN;
          cause_d = CAUSE_STEP;
        end else if (tmr_expired) begin
          state_d   = ST_DRAIN;
          cause_d   = CAUSE_STEP;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if ((state_q != ST_HALTED) && (state_d == ST_HALTED)) begin
      pc_d = core_next_pc;
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
    end

    // Outputs are registered copies of what the next state implies.
    fetch_stall_d = (state_d != ST_RUN);
    step_issue_d  = (state_d == ST_STEP_ISSUE);
    halted_d      = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cause_q       <= CAUSE_NONE;
      pc_q          <= '0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
      fetch_stall_q <= 1'b0;
      step_issue_q  <= 1'b0;
      halted_q      <= 1'b0;
      resume_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
      fetch_stall_q <= fetch_stall_d;
      step_issue_q  <= step_issue_d;
      halted_q      <= halted_d;
      resume_ack_q  <= resume_ack_d;
    end
  end

  assign fetch_stall   = fetch_stall_q;
  assign step_issue    = step_issue_q;
  assign halted        = halted_q;
  assign resume_ack    = resume_ack_q;
  assign halt_cause    = cause_q;
  assign halt_pc       = pc_q;
  assign drain_timeout = timeout_q;
  assign halt_count    = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// tb_debug_halt_ctrl
// Bench for debug_halt_ctrl. The driver plays halt episodes and, from the
// rules of the halt protocol, predicts each halt record (cause, resume PC,
// timeout flag, saturating count) and each resume acknowledge. A monitor pops
// and compares them whenever halted rises or resume_ack is seen.
module tb_debug_halt_ctrl;
  import debug_pkg::*;

  localparam int AW      = 64;
  localparam int DT      = 8;
  localparam int CW      = 3;
  localparam int RW      = 3 + 1 + CW + AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          debug_halt_request = 1'b0;
  logic          debug_single_step = 1'b0;
  logic          debug_breakpoint_hit = 1'b0;
  logic          debug_watchpoint_hit = 1'b0;
  logic          pipe_empty = 1'b0;
  logic          retire_valid = 1'b0;
  logic [AW-1:0] core_next_pc = '0;
  logic          fetch_stall;
  logic          step_issue;
  logic          halted;
  logic          resume_ack;
  logic [2:0]    halt_cause;
  logic [AW-1:0] halt_pc;
  logic          drain_timeout;
  logic [CW-1:0] halt_count;
  halt_state_t   dbg_state;

  debug_halt_ctrl #(
    .ADDR_WIDTH    (AW),
    .DRAIN_TIMEOUT (DT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .debug_halt_request   (debug_halt_request),
    .debug_single_step    (debug_single_step),
    .debug_breakpoint_hit (debug_breakpoint_hit),
    .debug_watchpoint_hit (debug_watchpoint_hit),
    .pipe_empty           (pipe_empty),
    .retire_valid         (retire_valid),
    .core_next_pc         (core_next_pc),
    .fetch_stall          (fetch_stall),
    .step_issue           (step_issue),
    .halted               (halted),
    .resume_ack           (resume_ack),
    .halt_cause           (halt_cause),
    .halt_pc              (halt_pc),
    .drain_timeout        (drain_timeout),
    .halt_count           (halt_count),
    .dbg_state            (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int model_count = 0;
  logic [RW-1:0] exp_q[$];
  logic [0:0]    ack_q[$];

  task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checkw(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Halt record: {cause, timeout, count, pc}.
  task automatic push_halt(input logic [2:0] cause, input logic to, input logic [AW-1:0] pc);
    model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
    exp_q.push_back({cause, to, CW'(model_count), pc});
  endtask

  // ---------------- monitor ----------------
  logic          prev_halted = 1'b0;
  logic [RW-1:0] rec;
  logic [0:0]    ack_tmp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_halted = 1'b0;
    end else begin
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_halt");
        end else begin
          rec = exp_q.pop_front();
          checkw("halt_cause", 64'(halt_cause), 64'(rec[RW-1 -: 3]));
          check1("halt_drain_timeout", drain_timeout, rec[AW+CW]);
          checkw("halt_count", 64'(halt_count), 64'(rec[AW +: CW]));
          checkw("halt_pc", halt_pc, rec[AW-1:0]);
        end
      end
      if (resume_ack) begin
        if (ack_q.size() == 0) begin
          fail_now("unexpected_resume_ack");
        end else begin
          ack_tmp = ack_q.pop_front();
          check1("ack_halted_low", halted, 1'b0);
          checkw("ack_cause_cleared", 64'(halt_cause), 64'(CAUSE_NONE));
          check1("ack_timeout_cleared", drain_timeout, 1'b0);
        end
      end
      prev_halted = halted;
    end
  end

  // ---------------- driver tasks ----------------
  // All driving happens right after a falling edge, after that edge's checks.
  task automatic noise(input bit allow_step);
    debug_breakpoint_hit = ($urandom_range(0, 2) == 0);
    debug_watchpoint_hit = ($urandom_range(0, 2) == 0);
    retire_valid         = ($urandom_range(0, 2) == 0);
    pipe_empty           = ($urandom_range(0, 1) == 0);
    debug_single_step    = allow_step && ($urandom_range(0, 3) == 0);
    core_next_pc         = {$urandom, $urandom};
  endtask

  task automatic quiet();
    debug_breakpoint_hit = 1'b0;
    debug_watchpoint_hit = 1'b0;
    retire_valid         = 1'b0;
    debug_single_step    = 1'b0;
  endtask

  // Entered at the falling edge of drain cycle 1. pipe_empty rises in drain
  // cycle k; the timer forces the halt at the end of drain cycle DT.
  task automatic drain_phase(input logic [2:0] cause, input int k, input bit fixed,
                             input logic [AW-1:0] fpc);
    int last;
    last = (k < DT) ? k : DT;
    for (int j = 1; j <= last; j++) begin
      check1("drain_stall", fetch_stall, 1'b1);
      check1("drain_not_halted", halted, 1'b0);
      noise(1'b1);
      core_next_pc = fixed ? fpc : {$urandom, $urandom};
      pipe_empty = (j >= k);
      if (j == last) push_halt(cause, (k > DT), core_next_pc);
      @(negedge clk);
    end
    check1("halted_reached", halted, 1'b1);
    check1("halted_stall", fetch_stall, 1'b1);
    quiet();
  endtask

  task automatic halt_from_run(input int k, input bit bp, input bit wp, input bit fixed,
                               input logic [AW-1:0] fpc);
    int idle;
    logic [2:0] cause;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      noise(1'b1);
      debug_halt_request = 1'b0;
      @(negedge clk);
      check1("idle_run_stall", fetch_stall, 1'b0);
    end
    check1("req_cycle_stall", fetch_stall, 1'b0);
    noise(1'b1);
    debug_halt_request   = 1'b1;
    debug_breakpoint_hit = bp;
    debug_watchpoint_hit = wp;
    cause = bp ? 3'd1 : (wp ? 3'd2 : 3'd3);
    @(negedge clk);
    drain_phase(cause, k, fixed, fpc);
  endtask

  task automatic resume();
    debug_halt_request = 1'b0;
    ack_q.push_back(1'b1);
    @(negedge clk);
    check1("resume_stall_low", fetch_stall, 1'b0);
    noise(1'b1);
    @(negedge clk);
    check1("resume_ack_one_cycle", resume_ack, 1'b0);
    quiet();
  endtask

  // Entered at a falling edge while HALTED. With drop=1 the request falls in
  // the same cycle as the step pulse; the step still runs and the block
  // resumes only after it re-halts.
  task automatic step_episode(input bit drop, input int k, input int r);
    check1("pre_step_halted", halted, 1'b1);
    debug_single_step = 1'b1;
    if (drop) debug_halt_request = 1'b0;
    @(negedge clk);
    check1("step_issue_on", step_issue, 1'b1);
    check1("step_halted_low", halted, 1'b0);
    check1("step_stall", fetch_stall, 1'b1);
    check1("step_no_resume_ack", resume_ack, 1'b0);
    debug_single_step = 1'b0;
    @(negedge clk);
    check1("step_issue_one_cycle", step_issue, 1'b0);
    for (int w = 1; w <= r; w++) begin
      noise(1'b0);
      retire_valid = (w == r);
      @(negedge clk);
      check1("step_wait_stall", fetch_stall, 1'b1);
      check1("step_wait_no_issue", step_issue, 1'b0);
    end
    retire_valid = 1'b0;
    if (drop) ack_q.push_back(1'b1);
    drain_phase(3'd4, k, 1'b0, '0);
    if (drop) begin
      @(negedge clk);
      check1("drop_resumed_stall", fetch_stall, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check1("rst_fetch_stall", fetch_stall, 1'b0);
    check1("rst_halted", halted, 1'b0);
    checkw("rst_halt_pc", halt_pc, 64'd0);
    checkw("rst_halt_count", 64'(halt_count), 64'd0);
    checkw("rst_state", 64'(dbg_state), 64'(ST_RUN));
    rst_n = 1'b1;
    @(negedge clk);

    // Three clean drain cycles then pipe_empty: halted five cycles after request.
    halt_from_run(4, 1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0040);
    resume();
    // Cause priority.
    halt_from_run($urandom_range(1, DT), 1'b1, 1'b1, 1'b0, '0);
    resume();
    halt_from_run($urandom_range(1, DT), 1'b0, 1'b1, 1'b0, '0);
    resume();
    // Single step with retire two cycles after step_issue.
    halt_from_run(2, 1'b0, 1'b0, 1'b0, '0);
    step_episode(1'b0, 1, 2);
    resume();
    // Forced halt by the drain timer, then a tie between pipe_empty and expiry.
    halt_from_run(DT + 3, 1'b0, 1'b0, 1'b0, '0);
    resume();
    halt_from_run(DT, 1'b0, 1'b0, 1'b0, '0);
    resume();
    // Step and request drop together.
    halt_from_run(1, 1'b0, 1'b0, 1'b0, '0);
    step_episode(1'b1, $urandom_range(1, 3), 2);

    // Random episodes; the narrow counter saturates along the way.
    for (int e = 0; e < 12; e++) begin
      int nsteps;
      halt_from_run($urandom_range(1, DT + 2), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0), 1'b0, '0);
      nsteps = $urandom_range(0, 2);
      for (int s = 0; s < nsteps; s++) begin
        step_episode(1'b0, $urandom_range(1, DT + 2), $urandom_range(1, 4));
      end
      resume();
    end
    checkw("count_saturated", 64'(halt_count), 64'(CNT_MAX));

    // Asynchronous reset while waiting for the stepped instruction.
    halt_from_run(1, 1'b0, 1'b0, 1'b0, '0);
    debug_single_step = 1'b1;
    @(negedge clk);
    debug_single_step = 1'b0;
    @(negedge clk);
    checkw("pre_reset_state", 64'(dbg_state), 64'(ST_STEP_WAIT));
    rst_n = 1'b0;
    #1;
    check1("async_rst_fetch_stall", fetch_stall, 1'b0);
    check1("async_rst_step_issue", step_issue, 1'b0);
    check1("async_rst_halted", halted, 1'b0);
    check1("async_rst_resume_ack", resume_ack, 1'b0);
    checkw("async_rst_cause", 64'(halt_cause), 64'd0);
    checkw("async_rst_pc", halt_pc, 64'd0);
    check1("async_rst_timeout", drain_timeout, 1'b0);
    checkw("async_rst_count", 64'(halt_count), 64'd0);
    checkw("async_rst_state", 64'(dbg_state), 64'(ST_RUN));
    debug_halt_request = 1'b0;
    model_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_stall", fetch_stall, 1'b0);
    checkw("post_rst_state", 64'(dbg_state), 64'(ST_RUN));

    // Counter restarts from zero after reset.
    halt_from_run($urandom_range(1, DT), 1'b0, 1'b0, 1'b0, '0);
    resume();

    repeat (2) @(negedge clk);
    checkw("halt_queue_drained", 64'(exp_q.size()), 64'd0);
    checkw("ack_queue_drained", 64'(ack_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
